// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction-fetch stage.
//   InstAddrBus / InstBus : default PC and instruction widths
//   ZeroWord              : all-zero instruction word
//   Enable / Disable      : single-bit control levels
//   fetch_state_e         : fetch FSM encoding (2 bits)
//   pc_sel_e              : next-PC source selector
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_HOLD   = 2'd0,  // keep current pc
    PC_SEL_INC    = 2'd1,  // sequential pc + PC_STEP
    PC_SEL_TARGET = 2'd2,  // redirect target presented this cycle
    PC_SEL_PEND   = 2'd3   // redirect target latched while a request was pending
  } pc_sel_e;

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Request/response bus between the fetch stage and instruction memory.
//   rom_req_o    : fetch request (fetch -> memory)
//   rom_addr_o   : fetch address, stable until granted (fetch -> memory)
//   rom_gnt_i    : request accepted this cycle (memory -> fetch)
//   rom_rvalid_i : read data valid, one per grant (memory -> fetch)
//   rom_rdata_i  : instruction word (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              rom_req_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_gnt_i;
  logic              rom_rvalid_i;
  logic [DATA_W-1:0] rom_rdata_i;

  modport master (
    output rom_req_o,
    output rom_addr_o,
    input  rom_gnt_i,
    input  rom_rvalid_i,
    input  rom_rdata_i
  );

  modport slave (
    input  rom_req_o,
    input  rom_addr_o,
    output rom_gnt_i,
    output rom_rvalid_i,
    output rom_rdata_i
  );

endinterface

// File: rtl/inst_fetch_pc_next_sel.sv
// -----------------------------------------------------------------------------
// inst_fetch_pc_next_sel
// Combinational next-PC selection for the fetch stage.
//   i_sel         : source select (hold / increment / target / pending target)
//   i_pc          : current program counter
//   i_target      : redirect target presented this cycle
//   i_pend_target : redirect target latched earlier
//   o_pc_next     : selected next program counter
// The increment wraps modulo 2^ADDR_W.
// -----------------------------------------------------------------------------
module inst_fetch_pc_next_sel
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W  = InstAddrBus,
  parameter int PC_STEP = 4
) (
  input  pc_sel_e           i_sel,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_target,
  input  logic [ADDR_W-1:0] i_pend_target,
  output logic [ADDR_W-1:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc;
    case (i_sel)
      PC_SEL_INC:    o_pc_next = i_pc + ADDR_W'(PC_STEP);
      PC_SEL_TARGET: o_pc_next = i_target;
      PC_SEL_PEND:   o_pc_next = i_pend_target;
      default:       o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory and presents the fetched word to IF/ID.
//   clk             : clock, all state changes on posedge
//   rst             : asynchronous active-low reset
//   stall_i         : downstream cannot accept; gates leaving HOLD only
//   branch_flag_i   : single-cycle redirect request
//   branch_target_i : redirect target
//   rom             : memory request/response bus (master side)
//   if_pc_o         : PC of presented instruction
//   if_inst_o       : presented instruction
//   if_valid_o      : if_pc_o / if_inst_o hold a real instruction
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBus,
  parameter int                DATA_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  inst_fetch_if.master      rom,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_valid_o
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_discard;      // next response belongs to a squashed fetch
  logic              r_pend;         // redirect seen while request not yet granted
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] r_if_pc;
  logic [DATA_W-1:0] r_if_inst;
  logic              r_if_valid;

  fetch_state_e      w_state_next;
  pc_sel_e           w_pc_sel;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_discard_next;
  logic              w_pend_next;
  logic [ADDR_W-1:0] w_pend_target_next;
  logic [ADDR_W-1:0] w_if_pc_next;
  logic [DATA_W-1:0] w_if_inst_next;
  logic              w_if_valid_next;

  inst_fetch_pc_next_sel #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP)
  ) u_pc_next_sel (
    .i_sel         (w_pc_sel),
    .i_pc          (r_pc),
    .i_target      (branch_target_i),
    .i_pend_target (r_pend_target),
    .o_pc_next     (w_pc_next)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= FETCH_IDLE;
      r_pc          <= RESET_PC;
      r_discard     <= Disable;
      r_pend        <= Disable;
      r_pend_target <= '0;
      r_if_pc       <= '0;
      r_if_inst     <= '0;
      r_if_valid    <= Disable;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_discard     <= w_discard_next;
      r_pend        <= w_pend_next;
      r_pend_target <= w_pend_target_next;
      r_if_pc       <= w_if_pc_next;
      r_if_inst     <= w_if_inst_next;
      r_if_valid    <= w_if_valid_next;
    end
  end

  // Next-state and datapath selection.
  always_comb begin
    w_state_next       = r_state;
    w_pc_sel           = PC_SEL_HOLD;
    w_discard_next     = r_discard;
    w_pend_next        = r_pend;
    w_pend_target_next = r_pend_target;
    w_if_pc_next       = r_if_pc;
    w_if_inst_next     = r_if_inst;
    w_if_valid_next    = r_if_valid;

    case (r_state)
      FETCH_IDLE: begin
        w_state_next = FETCH_REQ;
        if (branch_flag_i) begin
          w_pc_sel        = PC_SEL_TARGET;
          w_if_valid_next = Disable;
        end
      end

      FETCH_REQ: begin
        if (rom.rom_gnt_i) begin
          w_state_next = FETCH_WAIT;
          w_pend_next  = Disable;
          // The granted address is already stale if a redirect arrived; its
          // response must be dropped and the target fetched afterwards.
          if (branch_flag_i) begin
            w_discard_next = Enable;
            w_pc_sel       = PC_SEL_TARGET;
          end else if (r_pend) begin
            w_discard_next = Enable;
            w_pc_sel       = PC_SEL_PEND;
          end
        end else if (branch_flag_i) begin
          // Address must stay stable until granted, so park the target.
          w_pend_next        = Enable;
          w_pend_target_next = branch_target_i;
        end
      end

      FETCH_WAIT: begin
        if (branch_flag_i) begin
          w_pc_sel        = PC_SEL_TARGET;
          w_if_valid_next = Disable;
          if (rom.rom_rvalid_i) begin
            // Response arrives with the redirect: drop it and refetch now.
            w_discard_next = Disable;
            w_state_next   = FETCH_REQ;
          end else begin
            w_discard_next = Enable;
          end
        end else if (rom.rom_rvalid_i) begin
          w_discard_next = Disable;
          if (r_discard) begin
            w_state_next = FETCH_REQ;
          end else begin
            w_if_pc_next    = r_pc;
            w_if_inst_next  = rom.rom_rdata_i;
            w_if_valid_next = Enable;
            w_pc_sel        = PC_SEL_INC;
            w_state_next    = FETCH_HOLD;
          end
        end
      end

      FETCH_HOLD: begin
        if (branch_flag_i) begin
          w_pc_sel        = PC_SEL_TARGET;
          w_if_valid_next = Disable;
          w_state_next    = FETCH_REQ;
        end else if (!stall_i) begin
          w_if_valid_next = Disable;
          w_state_next    = FETCH_REQ;
        end
      end

      default: w_state_next = FETCH_IDLE;
    endcase
  end

  // Bus outputs decoded from state.
  always_comb begin
    rom.rom_req_o  = Disable;
    rom.rom_addr_o = '0;
    if (r_state == FETCH_REQ) begin
      rom.rom_req_o  = Enable;
      rom.rom_addr_o = r_pc;
    end
  end

  assign if_pc_o    = r_if_pc;
  assign if_inst_o  = r_if_inst;
  assign if_valid_o = r_if_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. A memory model answers requests with a
// programmable grant and response delay; it returns address XOR a tag so a
// pc/inst mix-up is visible. Expected instructions are queued by the stimulus
// and popped by a monitor each time IF/ID consumes (valid and not stalled).
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) rom_bus ();

  inst_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom             (rom_bus),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  int errors = 0;
  int checks = 0;
  int consumed = 0;
  logic [31:0] exp_q[$];

  int gnt_delay = 0;
  int rv_delay  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ TAG;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!if_valid_o && n < 50) begin
      step();
      n++;
    end
    check(name, {31'd0, if_valid_o}, 32'd1);
  endtask

  // Instruction memory: grant after gnt_delay request cycles, data rv_delay
  // cycles after the cycle following the grant.
  initial begin
    logic        m_pend;
    logic [31:0] m_addr;
    int          m_gcnt;
    int          m_rcnt;
    m_pend = 1'b0; m_addr = '0; m_gcnt = 0; m_rcnt = 0;
    rom_bus.rom_gnt_i    = 1'b0;
    rom_bus.rom_rvalid_i = 1'b0;
    rom_bus.rom_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      rom_bus.rom_gnt_i    = 1'b0;
      rom_bus.rom_rvalid_i = 1'b0;
      if (!rst) begin
        m_pend = 1'b0; m_gcnt = 0; m_rcnt = 0;
      end else begin
        if (m_pend) begin
          if (m_rcnt == 0) begin
            rom_bus.rom_rvalid_i = 1'b1;
            rom_bus.rom_rdata_i  = mem_word(m_addr);
            m_pend = 1'b0;
          end else begin
            m_rcnt--;
          end
        end
        if (rom_bus.rom_req_o && !m_pend) begin
          if (m_gcnt < gnt_delay) begin
            m_gcnt++;
          end else begin
            rom_bus.rom_gnt_i = 1'b1;
            m_addr = rom_bus.rom_addr_o;
            m_pend = 1'b1;
            m_rcnt = rv_delay;
            m_gcnt = 0;
          end
        end
      end
    end
  end

  // Monitor: an instruction is taken by IF/ID when valid and not stalled.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst && if_valid_o && !stall_i) begin
        consumed++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got pc=%h inst=%h expected none", if_pc_o, if_inst_o);
        end else begin
          e = exp_q.pop_front();
          $display("consume pc=%h inst=%h expect_pc=%h", if_pc_o, if_inst_o, e);
          check("sb_pc", if_pc_o, e);
          check("sb_inst", if_inst_o, mem_word(e));
        end
      end
    end
  end

  initial begin
    int req_cyc;
    int bad;
    int n;
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
    #1 rst = 1'b0;
    step(); step();

    // Reset state
    check("rst_req",   {31'd0, rom_bus.rom_req_o}, 32'd0);
    check("rst_addr",  rom_bus.rom_addr_o, 32'd0);
    check("rst_pc",    if_pc_o, 32'd0);
    check("rst_inst",  if_inst_o, 32'd0);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);

    // Sequential fetch, zero-wait memory; first valid 3 cycles after IDLE
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    rst = 1'b1;
    step();
    check("first_req",  {31'd0, rom_bus.rom_req_o}, 32'd1);
    check("first_addr", rom_bus.rom_addr_o, 32'h0);
    step();
    check("lat_not_yet", {31'd0, if_valid_o}, 32'd0);
    step();
    check("lat_valid", {31'd0, if_valid_o}, 32'd1);

    // Grant delayed 3 cycles for 0x4
    gnt_delay = 3; req_cyc = 0; bad = 0;
    for (int i = 0; i < 20 && !(if_valid_o && if_pc_o == 32'h4); i++) begin
      step();
      if (rom_bus.rom_req_o) begin
        req_cyc++;
        if (rom_bus.rom_addr_o != 32'h4) bad++;
      end
    end
    check("gnt_wait_addr_stable", bad, 0);
    check("gnt_wait_req_cycles", req_cyc, 4);
    check("gnt_wait_pc", if_pc_o, 32'h4);
    gnt_delay = 0;

    // Stall while holding 0x8
    step();
    stall_i = 1'b1;
    step(); step();
    check("stall_hold_pc", if_pc_o, 32'h8);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!if_valid_o || if_pc_o != 32'h8 || if_inst_o != mem_word(32'h8) || rom_bus.rom_req_o) bad++;
    end
    check("stall_frozen", bad, 0);
    rv_delay = 1;
    stall_i = 1'b0;
    step();
    check("after_stall_addr", rom_bus.rom_addr_o, 32'hC);

    // Branch to 0x100 while waiting for 0xC
    step();
    branch_flag_i = 1'b1; branch_target_i = 32'h100; rv_delay = 0;
    exp_q.push_back(32'h100);
    step();
    branch_flag_i = 1'b0;
    check("br_wait_inval", {31'd0, if_valid_o}, 32'd0);
    step();
    check("br_wait_req", {31'd0, rom_bus.rom_req_o}, 32'd1);
    check("br_wait_addr", rom_bus.rom_addr_o, 32'h100);
    wait_valid("br_wait_timeout");

    // Branch to 0x200 in the same cycle as rvalid
    step();
    check("seq_after_br_addr", rom_bus.rom_addr_o, 32'h104);
    step();
    check("rvalid_aligned", {31'd0, rom_bus.rom_rvalid_i}, 32'd1);
    branch_flag_i = 1'b1; branch_target_i = 32'h200;
    exp_q.push_back(32'h200);
    step();
    branch_flag_i = 1'b0;
    check("br_rv_inval", {31'd0, if_valid_o}, 32'd0);
    check("br_rv_addr", rom_bus.rom_req_o ? rom_bus.rom_addr_o : 32'hFFFF_FFFF, 32'h200);
    wait_valid("br_rv_timeout");

    // Branch to 0x300 while stalled in HOLD on 0x204
    step();
    stall_i = 1'b1;
    step(); step();
    check("stall_hold2_pc", if_pc_o, 32'h204);
    step();
    branch_flag_i = 1'b1; branch_target_i = 32'h300;
    exp_q.push_back(32'h300);
    step();
    branch_flag_i = 1'b0;
    check("br_stall_inval", {31'd0, if_valid_o}, 32'd0);
    check("br_stall_addr", rom_bus.rom_req_o ? rom_bus.rom_addr_o : 32'hFFFF_FFFF, 32'h300);
    wait_valid("br_stall_timeout");
    step(); step();
    check("br_stall_held_pc", if_valid_o ? if_pc_o : 32'hFFFF_FFFF, 32'h300);
    rv_delay = 3;
    stall_i = 1'b0;

    // Reset in the middle of WAIT
    step();
    check("pre_rst_addr", rom_bus.rom_addr_o, 32'h304);
    step(); step();
    rst = 1'b0;
    #1;
    check("mid_rst_req",   {31'd0, rom_bus.rom_req_o}, 32'd0);
    check("mid_rst_addr",  rom_bus.rom_addr_o, 32'd0);
    check("mid_rst_pc",    if_pc_o, 32'd0);
    check("mid_rst_inst",  if_inst_o, 32'd0);
    check("mid_rst_valid", {31'd0, if_valid_o}, 32'd0);
    rv_delay = 0; gnt_delay = 2;
    step(); step();
    rst = 1'b1;

    // Restart at RESET_PC; branch before grant to 0xFFFF_FFFC, then wrap to 0
    step();
    check("restart_addr", rom_bus.rom_req_o ? rom_bus.rom_addr_o : 32'hFFFF_FFFF, 32'h0);
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    step();
    branch_flag_i = 1'b0;
    check("pend_addr_stable", rom_bus.rom_req_o ? rom_bus.rom_addr_o : 32'hFFFF_FFFF, 32'h0);

    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    step(); step();
    check("queue_drained", exp_q.size(), 0);
    check("consumed_count", consumed, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
